// File: rtl/ecc_error_handler.sv
// ecc_error_handler
// -----------------
// This block sits after the ECC checker in the DDR3 read-return path. Each
// valid read beat is classified from its syndrome:
//   - clean: syndrome == 0
//   - CE (correctable): syndrome[7] == 1, single bit already corrected
//   - UE (uncorrectable): any other non-zero syndrome
//
// What the block does:
//   - Forwards the corrected data one cycle later, with a UE flag.
//   - Keeps saturating CE/UE counters and a sticky log of the first UE address.
//   - Raises a sticky interrupt.
//   - Queues CE beats as scrub write-back requests.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rd_valid, rd_addr, syndrome,
//   corrected_data                   read beat from the checker stage
//   data_out, data_valid, data_err   registered forward path (no backpressure)
//   scrub_valid/ready/addr/data      scrub request stream to the scheduler
//   ce_threshold                     CE count that raises irq (0 = disabled)
//   clear                            one-cycle pulse: clears counters, log, irq
//   ce_count, ue_count               saturating error counters
//   ue_addr, ue_logged               sticky first-UE log
//   scrub_drop                       sticky: a CE was dropped because the queue was full
//   irq                              sticky interrupt
//
// Scrub handshake:
//   - scrub_valid is high whenever the queue is non-empty.
//   - While scrub_valid is high, scrub_addr/scrub_data show the head entry.
//     They stay stable until the entry is taken.
//   - An entry transfers, and is popped, on every rising edge where
//     scrub_valid and scrub_ready are both high.
//   - scrub_valid never depends combinationally on scrub_ready.
module ecc_error_handler #(
  parameter int ADDR_W      = 28,
  parameter int SCRUB_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        syndrome,
  input  logic [63:0]       corrected_data,
  output logic [63:0]       data_out,
  output logic              data_valid,
  output logic              data_err,
  output logic              scrub_valid,
  input  logic              scrub_ready,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic [63:0]       scrub_data,
  input  logic [CNT_W-1:0]  ce_threshold,
  input  logic              clear,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic [ADDR_W-1:0] ue_addr,
  output logic              ue_logged,
  output logic              scrub_drop,
  output logic              irq
);

  localparam int PTR_W   = $clog2(SCRUB_DEPTH);
  localparam int ENTRY_W = ADDR_W + 64;

  // ---------------------------------------------------------------------------
  // Beat classification
  // ---------------------------------------------------------------------------
  logic beat_ce;
  logic beat_ue;

  assign beat_ce = rd_valid & syndrome[7];
  assign beat_ue = rd_valid & (syndrome != 8'h00) & ~syndrome[7];

  // ---------------------------------------------------------------------------
  // Forward path: one register stage. data_out holds between valid beats.
  // ---------------------------------------------------------------------------
  logic [63:0] data_out_q;
  logic        data_valid_q;
  logic        data_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      data_valid_q <= rd_valid;
      data_err_q   <= beat_ue;
      if (rd_valid) begin
        data_out_q <= corrected_data;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_err   = data_err_q;

  // ---------------------------------------------------------------------------
  // Scrub queue
  // ---------------------------------------------------------------------------
  // The pointers carry one extra wrap bit, so that full and empty can be told
  // apart when the index bits are equal.
  logic [ENTRY_W-1:0] mem_q [SCRUB_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;
  logic               drop_evt;
  logic [ENTRY_W-1:0] head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_pop   = ~fifo_empty & scrub_ready;
  // A pop in the same cycle frees a slot, so a push into a full queue still
  // lands in that case.
  assign fifo_push  = beat_ce & (~fifo_full | fifo_pop);
  assign drop_evt   = beat_ce & fifo_full & ~fifo_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // The storage has no reset. The outputs below are gated to zero while the
  // queue is empty, so stale or uninitialised entries never reach the outputs.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {rd_addr, corrected_data};
    end
  end

  assign head        = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign scrub_valid = ~fifo_empty;
  assign scrub_addr  = fifo_empty ? '0 : head[ENTRY_W-1:64];
  assign scrub_data  = fifo_empty ? '0 : head[63:0];

  // ---------------------------------------------------------------------------
  // Counters, UE log, drop flag and interrupt
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  ce_count_q, ce_count_d;
  logic [CNT_W-1:0]  ue_count_q, ue_count_d;
  logic [ADDR_W-1:0] ue_addr_q, ue_addr_d;
  logic              ue_logged_q, ue_logged_d;
  logic              scrub_drop_q, scrub_drop_d;
  logic              irq_q, irq_d;

  always_comb begin
    ce_count_d   = ce_count_q;
    ue_count_d   = ue_count_q;
    ue_addr_d    = ue_addr_q;
    ue_logged_d  = ue_logged_q;
    scrub_drop_d = scrub_drop_q;
    irq_d        = irq_q;
    if (clear) begin
      // clear has priority: an error beat in the same cycle is not recorded.
      ce_count_d   = '0;
      ue_count_d   = '0;
      ue_addr_d    = '0;
      ue_logged_d  = 1'b0;
      scrub_drop_d = 1'b0;
      irq_d        = 1'b0;
    end else begin
      if (beat_ce && (ce_count_q != '1)) begin
        ce_count_d = ce_count_q + 1'b1;
      end
      if (beat_ue && (ue_count_q != '1)) begin
        ue_count_d = ue_count_q + 1'b1;
      end
      if (beat_ue && !ue_logged_q) begin
        ue_addr_d   = rd_addr;
        ue_logged_d = 1'b1;
        irq_d       = 1'b1;
      end
      // The CE interrupt fires only when the count crosses the threshold.
      // Being above a threshold that was lowered later does not fire it.
      if ((ce_threshold != '0) && (ce_count_q < ce_threshold) &&
          (ce_count_d >= ce_threshold)) begin
        irq_d = 1'b1;
      end
      if (drop_evt) begin
        scrub_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_count_q   <= '0;
      ue_count_q   <= '0;
      ue_addr_q    <= '0;
      ue_logged_q  <= 1'b0;
      scrub_drop_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      ce_count_q   <= ce_count_d;
      ue_count_q   <= ue_count_d;
      ue_addr_q    <= ue_addr_d;
      ue_logged_q  <= ue_logged_d;
      scrub_drop_q <= scrub_drop_d;
      irq_q        <= irq_d;
    end
  end

  assign ce_count   = ce_count_q;
  assign ue_count   = ue_count_q;
  assign ue_addr    = ue_addr_q;
  assign ue_logged  = ue_logged_q;
  assign scrub_drop = scrub_drop_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_ecc_error_handler.sv
// tb_ecc_error_handler
// --------------------
// Bench for ecc_error_handler. It drives inputs on the falling edge and
// samples outputs on the next falling edge.
//
// The reference model works at transaction level:
//   - integer counters and plain flags;
//   - a queue (exp_q) holding the expected scrub requests in order.
//
// A second instance with CNT_W=3 is used to show counter saturation in a few
// beats.
module tb_ecc_error_handler;

  localparam int ADDR_W      = 28;
  localparam int SCRUB_DEPTH = 4;
  localparam int CNT_W       = 16;
  localparam int ENTRY_W     = ADDR_W + 64;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        syndrome;
  logic [63:0]       corrected_data;
  logic [63:0]       data_out;
  logic              data_valid;
  logic              data_err;
  logic              scrub_valid;
  logic              scrub_ready;
  logic [ADDR_W-1:0] scrub_addr;
  logic [63:0]       scrub_data;
  logic [CNT_W-1:0]  ce_threshold;
  logic              clear;
  logic [CNT_W-1:0]  ce_count;
  logic [CNT_W-1:0]  ue_count;
  logic [ADDR_W-1:0] ue_addr;
  logic              ue_logged;
  logic              scrub_drop;
  logic              irq;

  // Outputs of the narrow-counter instance
  logic [63:0]       s_data_out;
  logic              s_data_valid, s_data_err, s_scrub_valid;
  logic [ADDR_W-1:0] s_scrub_addr, s_ue_addr;
  logic [63:0]       s_scrub_data;
  logic [2:0]        s_ce_count, s_ue_count;
  logic              s_ue_logged, s_scrub_drop, s_irq;

  int n_checks = 0;
  int n_errors = 0;

  ecc_error_handler #(.ADDR_W(ADDR_W), .SCRUB_DEPTH(SCRUB_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .syndrome(syndrome), .corrected_data(corrected_data), .data_out(data_out),
    .data_valid(data_valid), .data_err(data_err), .scrub_valid(scrub_valid),
    .scrub_ready(scrub_ready), .scrub_addr(scrub_addr), .scrub_data(scrub_data),
    .ce_threshold(ce_threshold), .clear(clear), .ce_count(ce_count),
    .ue_count(ue_count), .ue_addr(ue_addr), .ue_logged(ue_logged),
    .scrub_drop(scrub_drop), .irq(irq)
  );

  ecc_error_handler #(.ADDR_W(ADDR_W), .SCRUB_DEPTH(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .syndrome(syndrome), .corrected_data(corrected_data), .data_out(s_data_out),
    .data_valid(s_data_valid), .data_err(s_data_err), .scrub_valid(s_scrub_valid),
    .scrub_ready(scrub_ready), .scrub_addr(s_scrub_addr), .scrub_data(s_scrub_data),
    .ce_threshold(ce_threshold[2:0]), .clear(clear), .ce_count(s_ce_count),
    .ue_count(s_ue_count), .ue_addr(s_ue_addr), .ue_logged(s_ue_logged),
    .scrub_drop(s_scrub_drop), .irq(s_irq)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] exp_q[$];
  logic               m_dv, m_derr, m_logged, m_drop, m_irq;
  logic [63:0]        m_dout;
  logic [ADDR_W-1:0]  m_ue_addr;
  int                 m_ce, m_ue;

  always @(posedge clk or negedge rst_n) begin : model
    bit is_ce, is_ue, q_full, q_pop;
    int old_ce;
    if (!rst_n) begin
      m_dv = 1'b0; m_derr = 1'b0; m_dout = '0;
      m_ce = 0; m_ue = 0; m_logged = 1'b0; m_ue_addr = '0;
      m_drop = 1'b0; m_irq = 1'b0;
      exp_q.delete();
    end else begin
      is_ce  = rd_valid && syndrome[7];
      is_ue  = rd_valid && (syndrome != 8'h00) && !syndrome[7];
      q_full = (exp_q.size() == SCRUB_DEPTH);
      q_pop  = (exp_q.size() != 0) && scrub_ready;
      m_dv   = rd_valid;
      m_derr = is_ue;
      if (rd_valid) m_dout = corrected_data;
      if (q_pop) void'(exp_q.pop_front());
      if (is_ce && (!q_full || q_pop)) exp_q.push_back({rd_addr, corrected_data});
      if (clear) begin
        m_ce = 0; m_ue = 0; m_logged = 1'b0; m_ue_addr = '0;
        m_drop = 1'b0; m_irq = 1'b0;
      end else begin
        if (is_ce) begin
          old_ce = m_ce;
          if (m_ce < CNT_MAX) m_ce = m_ce + 1;
          if (ce_threshold != 0 && old_ce < int'(ce_threshold) && m_ce >= int'(ce_threshold))
            m_irq = 1'b1;
        end
        if (is_ue) begin
          if (m_ue < CNT_MAX) m_ue = m_ue + 1;
          if (!m_logged) begin
            m_logged = 1'b1; m_ue_addr = rd_addr; m_irq = 1'b1;
          end
        end
        if (is_ce && q_full && !q_pop) m_drop = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Present one beat (called at a falling edge) and advance to the next
  // falling edge; the beat's effects are then visible on the outputs.
  task automatic step(input bit v, input logic [ADDR_W-1:0] a,
                      input logic [7:0] s, input logic [63:0] d);
    rd_valid = v; rd_addr = a; syndrome = s; corrected_data = d;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 8'h00, '0);
  endtask

  function automatic logic [7:0] rand_syn(input int kind);
    if (kind == 0) return 8'h00;
    if (kind == 1) return 8'h80 | 8'($urandom_range(0, 127));
    return 8'($urandom_range(1, 127));
  endfunction

  task automatic rand_beat(input int kind);
    step(1'b1, ADDR_W'($urandom), rand_syn(kind), {$urandom, $urandom});
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    idle();
    clear = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [255:0] flat;
    flat = {data_out, data_valid, data_err, scrub_valid, scrub_addr, scrub_data,
            ce_count, ue_count, ue_addr, ue_logged, scrub_drop, irq};
    n_checks++;
    if (flat !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, expected all zero", flat);
    end
  endtask

  task automatic test_clean();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      step(1'b1, ADDR_W'($urandom), 8'h00, d);
      n_checks++;
      if (data_out !== d || data_valid !== 1'b1 || data_err !== 1'b0) begin
        n_errors++;
        $display("FAIL clean_forward[%0d]: data=%h v=%b e=%b, expected data=%h v=1 e=0",
                 i, data_out, data_valid, data_err, d);
      end
      n_checks++;
      if (ce_count !== '0 || ue_count !== '0 || scrub_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL clean_counts[%0d]: ce=%0d ue=%0d sv=%b, expected 0 0 0",
                 i, ce_count, ue_count, scrub_valid);
      end
    end
    idle();
    n_checks++;
    if (data_valid !== 1'b0 || data_out !== m_dout) begin
      n_errors++;
      $display("FAIL clean_hold: v=%b data=%h, expected v=0 data=%h", data_valid, data_out, m_dout);
    end
  endtask

  task automatic test_ce_scrub();
    scrub_ready = 1'b0;
    step(1'b1, 28'h0000123, 8'h85, 64'hDEADBEEF_00000001);
    n_checks++;
    if (ce_count !== 16'd1 || data_err !== 1'b0) begin
      n_errors++;
      $display("FAIL ce_count: ce=%0d err=%b, expected 1 0", ce_count, data_err);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (scrub_valid !== 1'b1 || scrub_addr !== 28'h0000123 || scrub_data !== 64'hDEADBEEF_00000001) begin
        n_errors++;
        $display("FAIL scrub_hold[%0d]: v=%b addr=%h data=%h, expected 1 0000123 deadbeef00000001",
                 i, scrub_valid, scrub_addr, scrub_data);
      end
      idle();
    end
    scrub_ready = 1'b1;
    idle();
    n_checks++;
    if (scrub_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL scrub_pop: scrub_valid=%b, expected 0", scrub_valid);
    end
  endtask

  task automatic test_ue_log();
    step(1'b1, 28'h0000AAA, 8'h03, {$urandom, $urandom});
    n_checks++;
    if (data_err !== 1'b1 || irq !== 1'b1 || ue_logged !== 1'b1) begin
      n_errors++;
      $display("FAIL ue_first: err=%b irq=%b logged=%b, expected 1 1 1", data_err, irq, ue_logged);
    end
    step(1'b1, 28'h0000BBB, rand_syn(2), {$urandom, $urandom});
    n_checks++;
    if (data_err !== 1'b1 || ue_count !== 16'd2 || ue_addr !== 28'h0000AAA || scrub_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ue_second: err=%b ue=%0d addr=%h sv=%b, expected 1 2 0000aaa 0",
               data_err, ue_count, ue_addr, scrub_valid);
    end
    pulse_clear();
    n_checks++;
    if (ce_count !== '0 || ue_count !== '0 || ue_addr !== '0 || ue_logged !== 1'b0 ||
        irq !== 1'b0 || scrub_drop !== 1'b0) begin
      n_errors++;
      $display("FAIL ue_clear: ce=%0d ue=%0d addr=%h log=%b irq=%b drop=%b, expected all 0",
               ce_count, ue_count, ue_addr, ue_logged, irq, scrub_drop);
    end
  endtask

  task automatic test_fifo_full();
    int drained;
    scrub_ready = 1'b0;
    for (int i = 0; i < 5; i++) rand_beat(1);
    n_checks++;
    if (ce_count !== 16'd5 || scrub_drop !== 1'b1 || scrub_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL fifo_drop: ce=%0d drop=%b sv=%b, expected 5 1 1", ce_count, scrub_drop, scrub_valid);
    end
    pulse_clear();
    n_checks++;
    if (scrub_drop !== 1'b0 || scrub_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL fifo_clear_keeps: drop=%b sv=%b, expected 0 1", scrub_drop, scrub_valid);
    end
    // CE arriving while full with the scheduler accepting: pop frees the slot.
    scrub_ready = 1'b1;
    rand_beat(1);
    n_checks++;
    if (scrub_drop !== 1'b0 || ce_count !== 16'd1) begin
      n_errors++;
      $display("FAIL fifo_push_pop_full: drop=%b ce=%0d, expected 0 1", scrub_drop, ce_count);
    end
    drained = 0;
    rd_valid = 1'b0;
    for (int i = 0; i < 8 && scrub_valid; i++) begin
      logic [ENTRY_W-1:0] hd;
      hd = exp_q[0];
      n_checks++;
      if (scrub_addr !== hd[ENTRY_W-1:64] || scrub_data !== hd[63:0]) begin
        n_errors++;
        $display("FAIL fifo_entry[%0d]: addr=%h data=%h, expected %h %h",
                 i, scrub_addr, scrub_data, hd[ENTRY_W-1:64], hd[63:0]);
      end
      drained++;
      idle();
    end
    n_checks++;
    if (drained !== 4) begin
      n_errors++;
      $display("FAIL fifo_occupancy: drained %0d entries, expected 4", drained);
    end
  endtask

  task automatic test_threshold();
    scrub_ready = 1'b1;
    ce_threshold = 16'd3;
    pulse_clear();
    rand_beat(1);
    rand_beat(1);
    n_checks++;
    if (irq !== 1'b0 || ce_count !== 16'd2) begin
      n_errors++;
      $display("FAIL thr_below: irq=%b ce=%0d, expected 0 2", irq, ce_count);
    end
    rand_beat(1);
    n_checks++;
    if (irq !== 1'b1 || ce_count !== 16'd3) begin
      n_errors++;
      $display("FAIL thr_reached: irq=%b ce=%0d, expected 1 3", irq, ce_count);
    end
    idle();
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++;
      $display("FAIL thr_sticky: irq=%b, expected 1", irq);
    end
    ce_threshold = '0;
    pulse_clear();
  endtask

  task automatic test_saturation();
    scrub_ready = 1'b1;
    for (int i = 0; i < 10; i++) rand_beat(1);
    for (int i = 0; i < 9; i++) rand_beat(2);
    n_checks++;
    if (s_ce_count !== 3'd7 || s_ue_count !== 3'd7) begin
      n_errors++;
      $display("FAIL sat_narrow: ce=%0d ue=%0d, expected 7 7", s_ce_count, s_ue_count);
    end
    n_checks++;
    if (ce_count !== 16'd10 || ue_count !== 16'd9) begin
      n_errors++;
      $display("FAIL sat_wide: ce=%0d ue=%0d, expected 10 9", ce_count, ue_count);
    end
    pulse_clear();
  endtask

  // Clear coinciding with a CE: forwarded and queued, but not counted.
  task automatic test_clear_wins();
    scrub_ready = 1'b0;
    clear = 1'b1;
    step(1'b1, 28'h0000777, 8'h81, 64'h1234_5678_9ABC_DEF0);
    clear = 1'b0;
    n_checks++;
    if (ce_count !== '0 || scrub_valid !== 1'b1 || scrub_addr !== 28'h0000777 ||
        data_out !== 64'h1234_5678_9ABC_DEF0) begin
      n_errors++;
      $display("FAIL clear_wins: ce=%0d sv=%b addr=%h data=%h, expected 0 1 0000777 123456789abcdef0",
               ce_count, scrub_valid, scrub_addr, data_out);
    end
    scrub_ready = 1'b1;
    idle();
  endtask

  task automatic test_random();
    ce_threshold = 16'($urandom_range(0, 6));
    for (int i = 0; i < 400; i++) begin
      logic [ENTRY_W-1:0] hd;
      scrub_ready = ($urandom_range(0, 2) == 0);
      clear       = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) != 0) rand_beat($urandom_range(0, 2));
      else idle();
      hd = (exp_q.size() != 0) ? exp_q[0] : '0;
      n_checks++;
      if (data_valid !== m_dv || data_err !== m_derr || data_out !== m_dout) begin
        n_errors++;
        $display("FAIL rand_fwd[%0d]: v=%b e=%b d=%h, expected %b %b %h",
                 i, data_valid, data_err, data_out, m_dv, m_derr, m_dout);
      end
      n_checks++;
      if (scrub_valid !== (exp_q.size() != 0) ||
          (scrub_valid && (scrub_addr !== hd[ENTRY_W-1:64] || scrub_data !== hd[63:0]))) begin
        n_errors++;
        $display("FAIL rand_scrub[%0d]: v=%b addr=%h data=%h, expected occupancy %0d head %h",
                 i, scrub_valid, scrub_addr, scrub_data, exp_q.size(), hd);
      end
      n_checks++;
      if (int'(ce_count) != m_ce || int'(ue_count) != m_ue || ue_logged !== m_logged ||
          ue_addr !== m_ue_addr || scrub_drop !== m_drop || irq !== m_irq) begin
        n_errors++;
        $display("FAIL rand_status[%0d]: ce=%0d ue=%0d log=%b addr=%h drop=%b irq=%b, expected %0d %0d %b %h %b %b",
                 i, ce_count, ue_count, ue_logged, ue_addr, scrub_drop, irq,
                 m_ce, m_ue, m_logged, m_ue_addr, m_drop, m_irq);
      end
    end
    clear = 1'b0;
    ce_threshold = '0;
  endtask

  task automatic test_async_reset();
    logic [255:0] flat;
    pulse_clear();
    scrub_ready = 1'b0;
    while (scrub_valid) begin
      scrub_ready = 1'b1;
      idle();
    end
    scrub_ready = 1'b0;
    rand_beat(1);
    rand_beat(2);
    rand_beat(1);
    n_checks++;
    if (exp_q.size() != 2 || scrub_valid !== 1'b1 || ue_logged !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_setup: model occupancy %0d sv=%b log=%b, expected 2 1 1",
               exp_q.size(), scrub_valid, ue_logged);
    end
    // Mid-cycle reset, with a CE beat on the inputs
    rd_valid = 1'b1; syndrome = 8'h90; corrected_data = {$urandom, $urandom};
    #2 rst_n = 1'b0;
    #1;
    flat = {data_out, data_valid, data_err, scrub_valid, scrub_addr, scrub_data,
            ce_count, ue_count, ue_addr, ue_logged, scrub_drop, irq};
    n_checks++;
    if (flat !== '0) begin
      n_errors++;
      $display("FAIL areset_immediate: got %h, expected all zero", flat);
    end
    @(negedge clk);
    rd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    n_checks++;
    if (scrub_valid !== 1'b0 || ce_count !== '0 || ue_logged !== 1'b0 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL areset_release: sv=%b ce=%0d log=%b irq=%b, expected 0 0 0 0",
               scrub_valid, ce_count, ue_logged, irq);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    rd_valid = 1'b0; rd_addr = '0; syndrome = '0; corrected_data = '0;
    scrub_ready = 1'b0; ce_threshold = '0; clear = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean();
    test_ce_scrub();
    test_ue_log();
    test_fifo_full();
    test_threshold();
    test_saturation();
    test_clear_wins();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
